// File: rtl/mux_8_arbiter.sv
// mux_8_arbiter: round-robin arbiter sharing one 8:1 single-bit mux.
// Optional MUX8_ARB_LOCK_EN adds a lock input that extends a tenure.
module mux_8_arbiter #(
    parameter int N        = 8,
    parameter int SEL_W    = $clog2(N),
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     data,
    input  logic             out_ready,
`ifdef MUX8_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] select,
    output logic             out,
    output logic             out_valid,
    output logic             busy
);

    localparam int HOLD_W = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold;
    logic [SEL_W-1:0]  ptr;

    logic              hold_lock;
    logic              cur_req;
    logic              xfer;
    logic              at_last;
    logic              rel;
    logic [SEL_W-1:0]  sel_inc;
    logic [SEL_W-1:0]  arb_base;
    logic [N-1:0]      arb_mask;
    logic [SEL_W-1:0]  cand;
    logic [SEL_W-1:0]  win_idx;
    logic              win_any;

`ifdef MUX8_ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    // Shared mux and its valid qualifier.
    assign out       = data[select];
    assign out_valid = (state == GRANT) & cur_req;

    // Tenure bookkeeping: transfer, last-transfer and release detection.
    always_comb begin
        cur_req = req[select];
        xfer    = (state == GRANT) & cur_req & out_ready;
        at_last = (hold == HOLD_LAST);
        rel     = (state == GRANT)
                & (~cur_req | (xfer & at_last & ~hold_lock));
        sel_inc = select + 1'b1;
    end

    // Round-robin search; on release start after the owner and skip it.
    always_comb begin
        arb_base = rel ? sel_inc : ptr;
        arb_mask = rel ? (req & ~grant) : req;
        win_any  = 1'b0;
        win_idx  = '0;
        cand     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = arb_base + SEL_W'(k);
            if (arb_mask[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant FSM with registered grant, select, busy, hold count and pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            select <= '0;
            busy   <= 1'b0;
            hold   <= '0;
            ptr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        state  <= GRANT;
                        grant  <= N'(1) << win_idx;
                        select <= win_idx;
                        busy   <= 1'b1;
                        hold   <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr  <= sel_inc;
                        hold <= '0;
                        if (win_any) begin
                            grant  <= N'(1) << win_idx;
                            select <= win_idx;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (xfer && !at_last) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_8_arbiter.sv
// tb_mux_8_arbiter: scoreboard bench with a queue-free round-robin model.
// Directed phases followed by randomized sticky requests and backpressure.
module tb_mux_8_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef MUX8_ARB_LOCK_EN
    localparam bit HAS_LOCK = 1'b1;
`else
    localparam bit HAS_LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data;
    logic       out_ready;
    logic       lock;
    logic [7:0] grant;
    logic [2:0] select;
    logic       out;
    logic       out_valid;
    logic       busy;

    always #5 clk = ~clk;

    mux_8_arbiter #(
        .N(8),
        .SEL_W(3),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .data(data),
        .out_ready(out_ready),
`ifdef MUX8_ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(grant),
        .select(select),
        .out(out),
        .out_valid(out_valid),
        .busy(busy)
    );

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
        logic       v;
    } exp_t;

    exp_t cq[$];
    logic dq[$];

    int tests = 0;
    int fails = 0;
    int exp_xfers = 0;
    int got_xfers = 0;

    // Reference model: owner index (-1 idle), pointer, transfers this tenure.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_sel   = 0;

    function automatic int search(logic [7:0] r, int start, int excl);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (start + k) % 8;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model(input logic rn, input logic [7:0] r,
                         input logic rdy, input logic l);
        int  w;
        bit  xf;
        bit  rel;
        bit  lk;
        lk = l & HAS_LOCK;
        if (!rn) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_sel   = 0;
            return;
        end
        if (m_owner < 0) begin
            w = search(r, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 0;
            end
        end else begin
            xf  = r[m_owner] && rdy;
            rel = !r[m_owner] || (xf && m_cnt == MAX_HOLD - 1 && !lk);
            if (rel) begin
                m_ptr   = (m_owner + 1) % 8;
                w       = search(r, m_ptr, m_owner);
                m_owner = w;
                m_cnt   = 0;
                if (w >= 0) m_sel = w;
            end else if (xf && m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    // One cycle of stimulus: drive, record expectations, advance model.
    task automatic step(input logic rn, input logic [7:0] r,
                        input logic [7:0] d, input logic rdy,
                        input logic l);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        req       = r;
        data      = d;
        out_ready = rdy;
        lock      = l;
        e.b = (m_owner >= 0);
        e.g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.s = 3'(m_sel);
        e.v = (m_owner >= 0) && r[m_owner];
        cq.push_back(e);
        if (e.v && rdy) begin
            dq.push_back(d[m_owner]);
            exp_xfers++;
        end
        model(rn, r, rdy, l);
    endtask

    // Monitor: pops one expectation per cycle and one bit per handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cq.size() != 0) begin
                e = cq.pop_front();
                check("grant", 32'(grant), 32'(e.g));
                check("busy", 32'(busy), 32'(e.b));
                check("out_valid", 32'(out_valid), 32'(e.v));
                if (e.b) check("select", 32'(select), 32'(e.s));
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    got_xfers++;
                    check("xfer_pending", 32'(dq.size() > 0), 32'd1);
                    if (dq.size() > 0)
                        check("out", 32'(out), 32'(dq.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic       l;
        rst_n     = 1'b0;
        req       = 8'hFF;
        data      = 8'h00;
        out_ready = 1'b1;
        lock      = 1'b0;
        model(1'b0, 8'hFF, 1'b1, 1'b0);

        // Reset with all requests, then index 0 wins.
        repeat (3) step(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
        repeat (3) step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);

        // Lone requester 2: four transfers, one idle cycle, re-grant.
        step(1'b0, 8'h04, 8'h04, 1'b1, 1'b0);
        repeat (14) step(1'b1, 8'h04, 8'h04, 1'b1, 1'b0);

        // All requesting: full rotation with no bubbles.
        step(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
        repeat (40) step(1'b1, 8'hFF, 8'hA5, 1'b1, 1'b0);

        // Backpressure on index 5 stalls without counting.
        step(1'b0, 8'h20, 8'h20, 1'b0, 1'b0);
        repeat (11) step(1'b1, 8'h20, 8'h20, 1'b0, 1'b0);
        repeat (7) step(1'b1, 8'h20, 8'h20, 1'b1, 1'b0);

        // Early release of index 3 hands off to 7.
        step(1'b0, 8'h08, 8'h08, 1'b1, 1'b0);
        step(1'b1, 8'h08, 8'h08, 1'b1, 1'b0);
        repeat (2) step(1'b1, 8'h88, 8'h88, 1'b1, 1'b0);
        repeat (4) step(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
        repeat (3) step(1'b1, 8'h88, 8'h08, 1'b1, 1'b0);

        // Lock held on index 0, then dropped.
        step(1'b0, 8'h03, 8'h01, 1'b1, 1'b1);
        repeat (12) step(1'b1, 8'h03, 8'h01, 1'b1, 1'b1);
        repeat (6) step(1'b1, 8'h03, 8'h01, 1'b1, 1'b0);

        // Random sticky requests, backpressure, lock and rare resets.
        r = 8'h00;
        l = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 15) == 0) l = ~l;
            step(($urandom_range(0, 99) != 0), r, 8'($urandom),
                 ($urandom_range(0, 3) != 0), l);
        end

        @(negedge clk);
        #1;
        check("cq_drained", 32'(cq.size()), 32'd0);
        check("dq_drained", 32'(dq.size()), 32'd0);
        check("xfer_count", 32'(got_xfers), 32'(exp_xfers));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_8_arbiter.md
Name: mux_8_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 single-bit mux among eight requesters.
- Each requester i presents req[i] and a data bit data[i]. The block grants one requester at a time and drives the mux select.
- It forwards the selected bit downstream with a valid/ready handshake.
- It bounds each tenure to MAX_HOLD transfers so no requester starves the others.

Parameters:
N, 8, number of requesters; fixed at 8 for this revision, sets SEL_W.
SEL_W, 3, select width, equal to $clog2(N).
MAX_HOLD, 4, maximum accepted transfers per grant tenure; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
req  input  N  per-requester request, level-sensitive.
data  input  N  per-requester data bit; data[i] belongs to req[i].
out_ready  input  1  downstream accepts out this cycle.
grant  output  N  one-hot registered grant; all zero when idle.
select  output  SEL_W  registered mux select = index of the granted requester.
out  output  1  data[select]; combinational through the internal 8:1 mux.
out_valid  output  1  valid qualifier for out.
busy  output  1  high while a grant is held.

Behaviour:
- Reset (rst_n low at an edge): grant=0, select=0, busy=0, out_valid=0, hold count=0, priority pointer ptr=0. This also applies mid-tenure: the grant is dropped at that edge and no transfer counts in that cycle.
- Two states:
  - IDLE: grant=0, busy=0.
  - GRANT: grant=onehot(select), busy=1.
- Arbitration:
  - Search req starting at index ptr, ascending, wrapping 7->0. The first set bit wins.
  - The search is combinational on the current req. The winner is registered into grant/select at the same edge, so latency is req-high edge to grant-high = 1 cycle.
- IDLE -> GRANT: at an edge where any req bit is 1. hold count <= 0.
- out_valid = (state==GRANT) & req[select] (combinational). out = data[select] at all times, including while idle.
- Transfer: out_valid & out_ready at an edge. It increments the hold count. out_ready low stalls the tenure without counting; there is no timeout on backpressure.
- Release condition, evaluated at an edge while in GRANT. Either of:
  - req[select]==0; or
  - a transfer occurs and hold count == MAX_HOLD-1 (that is, the MAX_HOLD-th transfer).
- On release:
  - ptr <= select+1 (mod 8).
  - Re-arbitrate in the same edge using the new ptr, with the releasing requester excluded. That requester is eligible again from the following cycle.
  - If there is a winner, stay in GRANT with the new select and hold count <= 0 (back-to-back handoff, no idle bubble). Otherwise go to IDLE.
- Requester alone on the bus: after a MAX_HOLD release it gets 1 idle cycle, then is re-granted.
- Requests arriving for other indices during a tenure have no effect until release.
- grant is always one-hot or zero; select never changes mid-tenure.

Optional Feature:
- Macro: MUX8_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit), placed after out_ready.
  - While in GRANT with lock==1 at an edge, the MAX_HOLD release is suppressed; the hold count saturates at MAX_HOLD-1.
  - Release on req[select] dropping still applies.
  - The lock value in IDLE is ignored.
- Undefined: no lock port; tenure always bounded by MAX_HOLD.

Test Plan:
1. Reset with req=8'hFF held for 3 cycles -> grant=0, busy=0, out_valid=0. After rst_n high, next edge gives grant=8'h01, select=0.
2. req=8'b0000_0100, data=8'b0000_0100, out_ready=1, MAX_HOLD=4 -> select=2, out=1, out_valid=1 for exactly 4 transfers. Then grant=0 for 1 cycle, then re-granted to index 2.
3. req=8'hFF, out_ready=1 -> grant order 0,1,2,...,7,0 with 4 transfers each and no idle cycle between tenures. select matches grant index.
4. Grant held on index 5, out_ready=0 for 10 cycles -> grant stays 8'h20, hold count stays 0. Raising out_ready then gives 4 transfers.
5. Index 3 granted with req=8'b1000_1000; drop req[3] after 2 transfers -> next edge grant=8'h80 (index 7). ptr=4 afterwards.
6. With MUX8_ARB_LOCK_EN defined: lock=1, req=8'h03, index 0 granted -> 10 transfers without release. Dropping lock releases at the next transfer edge, then grant=8'h02.
